// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encodings, default operand width and counter sizing.
package seq_multiplier_pkg;

  localparam int MUL_N_DEFAULT = 32;

  // Encodings are fixed so other blocks can decode the debug state directly.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_e;

  // Width of the iteration counter; it has to reach N-1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_32_bit.sv
// Ripple-carry adder: the single adder the multiplier uses each iteration.
// The default width is 32; N sets the operand width.
module adder_32_bit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  // Bit-serial ripple; the carry is a block-local variable, so no signal
  // depends on itself.
  always_comb begin
    logic carry;
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < N; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier. It produces a 2N-bit product
// in N cycles, using one N-bit ripple adder.
//
// Handshake: start is sampled only in IDLE. On the accept edge the operands
// are latched and busy rises. busy stays high for the N RUN iterations.
// done is a one-cycle pulse that follows the last iteration; product is
// valid while done is high and holds until the next result is written.
// busy and done are never high together. A start seen in RUN or DONE is
// dropped, not queued.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int N = MUL_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [1:0]     state_o
);

  localparam int            CW       = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mul_state_e     state_q,   state_d;
  logic [N-1:0]   mcand_q,   mcand_d;
  logic [N-1:0]   p_hi_q,    p_hi_d;
  logic [N-1:0]   p_lo_q,    p_lo_d;
  logic [CW-1:0]  count_q,   count_d;
  logic [2*N-1:0] product_q, product_d;
  logic           busy_q,    busy_d;
  logic           done_q,    done_d;

  // Adder operands: the upper partial product, plus the multiplicand when the
  // current multiplier bit is set.
  logic [N-1:0] addend;
  logic [N-1:0] sum;
  logic         carry;

  assign addend = p_lo_q[0] ? mcand_q : '0;

  adder_32_bit #(.N(N)) u_adder (
    .a_i   (p_hi_q),
    .b_i   (addend),
    .cin_i (1'b0),
    .sum_o (sum),
    .cout_o(carry)
  );

  // Next-state, datapath and output logic. Every value defaults to a hold.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_hi_d    = p_hi_q;
    p_lo_d    = p_lo_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = done_q;

    unique case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
          mcand_d = A;
          p_lo_d  = B;
          p_hi_d  = '0;
          count_d = '0;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        // Shift {carry, sum, p_lo} right by one. The carry becomes the MSB of
        // p_hi, so no bit of the product is lost.
        p_hi_d  = {carry, sum[N-1:1]};
        p_lo_d  = {sum[0], p_lo_q[N-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == CNT_LAST) begin
          state_d   = S_DONE;
          product_d = {carry, sum[N-1:1], sum[0], p_lo_q[N-1:1]};
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State register. Reset clears everything and takes priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      p_hi_q    <= p_hi_d;
      p_lo_q    <= p_lo_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign state_o = state_q;

endmodule
